top: RTL and testbench

TOP -- requirements
Module: top

---
 rtl/scheme_pkg.sv | 13 +
 rtl/scheme_if.sv | 17 +
 rtl/mux_n.sv | 21 ++
 rtl/top.sv | 53 +++++
 tb/tb_top.sv | 141 ++++++++++++++
 5 files changed

// File: rtl/scheme_pkg.sv
// Shared constants and types for the parallel-to-serial multiplexer block.
package scheme_pkg;

  // Default width of the parallel input word. It must be a power of two and at least 2.
  localparam int DATA_W = 8;

  // Select counter width, derived from DATA_W. This value is not overridden.
  localparam int SEL_W = $clog2(DATA_W);

  // Select counter type at the default width.
  typedef logic [SEL_W-1:0] sel_t;

endpackage : scheme_pkg

// File: rtl/scheme_if.sv
// Bus bundle for the serialiser: parallel word in, serial bit out.
interface scheme_if
  import scheme_pkg::*;
#(
  parameter int DATA_W = scheme_pkg::DATA_W
) ();

  logic [DATA_W-1:0] sn1;
  logic              y;

  // The master drives the word and receives the serial bit.
  modport master (output sn1, input y);

  // The slave is the serialiser itself.
  modport slave (input sn1, output y);

endinterface : scheme_if

// File: rtl/mux_n.sv
// Combinational DATA_W:1 multiplexer. The decode is full, so every select
// value returns the addressed bit and never X.
module mux_n
  import scheme_pkg::*;
#(
  parameter int DATA_W = scheme_pkg::DATA_W,
  parameter int SEL_W  = $clog2(DATA_W)
) (
  input  logic [DATA_W-1:0] data,
  input  logic [SEL_W-1:0]  sel,
  output logic              y
);

  // Pick the bit that sel addresses. DATA_W is a power of two, so the
  // index is always in range.
  always_comb begin
    y = 1'b0;
    y = data[sel];
  end

endmodule : mux_n

// File: rtl/top.sv
// Serialiser: a free-running select counter walks through the bits of sn1.
// Each bit is registered onto y, one bit per clock.
module top
  import scheme_pkg::*;
#(
  parameter int DATA_W = scheme_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sn1,
  output logic              y
);

  localparam int SEL_W = $clog2(DATA_W);

  // Counter step. Both this and the counter are SEL_W bits wide, so the
  // increment wraps from DATA_W-1 back to 0 on its own.
  localparam logic [SEL_W-1:0] SEL_ONE = {{(SEL_W-1){1'b0}}, 1'b1};

  logic [SEL_W-1:0] sel_r;
  logic             y_r;
  logic             mux_s;

  mux_n #(
    .DATA_W (DATA_W),
    .SEL_W  (SEL_W)
  ) u_mux (
    .data (sn1),
    .sel  (sel_r),
    .y    (mux_s)
  );

  // Free-running select counter. It is cleared asynchronously while reset is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_r <= {SEL_W{1'b0}};
    end else begin
      sel_r <= sel_r + SEL_ONE;
    end
  end

  // Output register. It captures the bit selected by the pre-increment count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y_r <= 1'b0;
    end else begin
      y_r <= mux_s;
    end
  end

  assign y = y_r;

endmodule : top

// File: tb/tb_top.sv
// Directed testbench for top. Each step pushes the expected serial bit into a
// scoreboard queue when it drives sn1. The bit is popped and compared just
// after the clock edge that should produce it.
module tb_top;
  import scheme_pkg::*;

  logic clk;
  logic reset;

  scheme_if #(.DATA_W(8)) bus ();

  top #(.DATA_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .sn1   (bus.sn1),
    .y     (bus.y)
  );

  int   n_cmp;
  int   n_err;
  logic exp_q[$];
  logic [2:0] msel;
  logic hold_exp;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input logic obs, input logic expv, input string tag);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic check_sel(input string tag);
    n_cmp++;
    assert (dut.sel_r === 3'd0) else begin
      n_err++;
      $error("FAIL %s: observed sel %0d expected 0", tag, dut.sel_r);
    end
  endtask

  // Drive one word at the falling edge and predict the bit for the next rising edge.
  // Check that bit just after the edge, and check that y holds at the next falling edge.
  task automatic step(input logic [7:0] d, input string tag);
    logic e;
    bus.sn1 = d;
    exp_q.push_back(d[msel]);
    msel = msel + 3'd1;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s: scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      check(bus.y, e, tag);
      hold_exp = e;
    end
    @(negedge clk);
    check(bus.y, hold_exp, {tag, "_hold"});
  endtask

  // Assert reset at a falling edge and check the asynchronous clear. Hold for two
  // edges, then release at a falling edge.
  task automatic do_reset(input string tag);
    reset = 1'b0;
    #1;
    check(bus.y, 1'b0, {tag, "_async_y"});
    check_sel({tag, "_async_sel"});
    repeat (2) begin
      @(posedge clk);
      #1;
      check(bus.y, 1'b0, {tag, "_held_y"});
      check_sel({tag, "_held_sel"});
    end
    @(negedge clk);
    reset = 1'b1;
    msel = 3'd0;
    exp_q.delete();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    msel = 3'd0;
    hold_exp = 1'b0;
    reset = 1'b0;
    bus.sn1 = 8'hFF;

    // Reset held with sn1 = 0xFF while the clock runs.
    repeat (4) begin
      @(posedge clk);
      #1;
      check(bus.y, 1'b0, "rst_y");
      check_sel("rst_sel");
    end
    @(negedge clk);
    reset = 1'b1;
    msel = 3'd0;

    // All ones.
    for (int i = 0; i < 10; i++) step(8'hFF, "ones");

    // Single LSB: y is high after edges 1, 9 and 17.
    do_reset("r_lsb");
    for (int i = 0; i < 20; i++) step(8'h01, "lsb");

    // MSB only: y is high after edges 8 and 16.
    do_reset("r_msb");
    for (int i = 0; i < 17; i++) step(8'h80, "msb");

    // Alternating patterns.
    do_reset("r_aa");
    for (int i = 0; i < 8; i++) step(8'hAA, "alt_aa");
    do_reset("r_55");
    for (int i = 0; i < 8; i++) step(8'h55, "alt_55");

    // Mid-run reset between edges, then check that the first sample is bit 0.
    do_reset("r_mid");
    for (int i = 0; i < 5; i++) step(8'hFF, "mid_pre");
    do_reset("mid");
    for (int i = 0; i < 9; i++) step(8'hFE, "mid_post");

    // A new random word every cycle. Only the bit addressed at each edge matters.
    do_reset("r_rnd");
    for (int i = 0; i < 24; i++) step(8'($urandom_range(0, 255)), "rnd");

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL drain: observed %0d left expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_top
